cfs_apb_master_arbiter: RTL and testbench

- APB master that shares one APB bus among NUM_REQ internal requesters.
- Round-robin arbitration; one transfer in flight at a time.
- Sequences the APB IDLE -> SETUP -> ACCESS phases and returns read data and error status to the granted requester.
- Access-phase watchdog terminates transfers that never see PREADY.

---
 rtl/cfs_apb_master_arbiter.sv | 171 +++++++++++++++++
 tb/tb_cfs_apb_master_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfs_apb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cfs_apb_master_arbiter
// Description : Round-robin APB master shared by NUM_REQ requesters, with an
//               access-phase watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module cfs_apb_master_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          pclk,
    input  logic                          preset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            done,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic                          rsp_timeout,
    output logic                          psel,
    output logic                          penable,
    output logic                          pwrite,
    output logic [ADDR_WIDTH-1:0]         paddr,
    output logic [DATA_WIDTH-1:0]         pwdata,
    input  logic [DATA_WIDTH-1:0]         prdata,
    input  logic                          pready,
    input  logic                          pslverr
);

    localparam int c_idx_w = $clog2(NUM_REQ);
    localparam int c_cnt_w = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_idx_w:0]   c_num_req  = (c_idx_w + 1)'(NUM_REQ);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_REQ - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_idx_w-1:0]    r_gnt_idx;
    logic [c_idx_w-1:0]    r_rr_ptr;
    logic [c_idx_w-1:0]    w_sel_idx;
    logic                  w_sel_valid;
    logic [c_idx_w:0]      w_cand;
    logic [c_cnt_w-1:0]    r_wd_cnt;
    logic                  w_timeout_hit;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_pwrite;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;
    logic                  r_timeout;

    logic [ADDR_WIDTH-1:0] w_slice_addr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_slice_wdata [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign w_slice_addr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_slice_wdata[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // First asserted request at or above rr_ptr, wrapping back to index 0.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_idx   = r_rr_ptr;
        w_cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, r_rr_ptr} + (c_idx_w + 1)'(k);
            if (w_cand >= c_num_req) begin
                w_cand = w_cand - c_num_req;
            end
            if (!w_sel_valid && req[w_cand[c_idx_w-1:0]]) begin
                w_sel_valid = 1'b1;
                w_sel_idx   = w_cand[c_idx_w-1:0];
            end
        end
    end

    assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && (r_wd_cnt == c_cnt_last);

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_sel_valid) w_state_nxt = S_SETUP;
            S_SETUP:  w_state_nxt = S_ACCESS;
            S_ACCESS: if (pready || w_timeout_hit) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_gnt_idx <= '0;
            r_rr_ptr  <= '0;
            r_wd_cnt  <= '0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pwrite  <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_sel_valid) begin
                        r_gnt_idx <= w_sel_idx;
                        r_paddr   <= w_slice_addr[w_sel_idx];
                        r_pwdata  <= w_slice_wdata[w_sel_idx];
                        r_pwrite  <= req_write[w_sel_idx];
                    end
                end
                S_ACCESS: begin
                    // A ready slave on the limit edge still completes normally.
                    if (pready) begin
                        r_rdata   <= r_pwrite ? '0 : prdata;
                        r_err     <= pslverr;
                        r_timeout <= 1'b0;
                    end else if (w_timeout_hit) begin
                        r_rdata   <= '0;
                        r_err     <= 1'b1;
                        r_timeout <= 1'b1;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_rr_ptr <= (r_gnt_idx == c_last_idx) ? '0 : r_gnt_idx + 1'b1;
                    r_wd_cnt <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        done = '0;
        if (r_state == S_DONE) begin
            done[r_gnt_idx] = 1'b1;
        end
    end

    assign psel        = (r_state == S_SETUP) || (r_state == S_ACCESS);
    assign penable     = (r_state == S_ACCESS);
    assign paddr       = r_paddr;
    assign pwdata      = r_pwdata;
    assign pwrite      = r_pwrite;
    assign rsp_rdata   = (r_state == S_DONE) ? r_rdata : '0;
    assign rsp_err     = (r_state == S_DONE) && r_err;
    assign rsp_timeout = (r_state == S_DONE) && r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_cfs_apb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cfs_apb_master_arbiter
// Description : Vector-table and scoreboard bench for cfs_apb_master_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cfs_apb_master_arbiter;

    logic         pclk;
    logic         preset_n;
    logic [3:0]   req;
    logic [63:0]  req_addr;
    logic [3:0]   req_write;
    logic [127:0] req_wdata;
    logic [3:0]   done;
    logic [31:0]  rsp_rdata;
    logic         rsp_err;
    logic         rsp_timeout;
    logic         psel;
    logic         penable;
    logic         pwrite;
    logic [15:0]  paddr;
    logic [31:0]  pwdata;
    logic [31:0]  prdata;
    logic         pready;
    logic         pslverr;

    cfs_apb_master_arbiter #(
        .NUM_REQ        (4),
        .ADDR_WIDTH     (16),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (16)
    ) u_dut (
        .pclk        (pclk),
        .preset_n    (preset_n),
        .req         (req),
        .req_addr    (req_addr),
        .req_write   (req_write),
        .req_wdata   (req_wdata),
        .done        (done),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        int          idx;
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        logic        slverr;
        int          waits;      // ACCESS cycles with pready=0; 255 = never ready
        logic [31:0] e_rdata;
        logic        e_err;
        logic        e_to;
        int          e_acc;      // expected ACCESS-phase length
    } vec_t;

    typedef struct {
        logic [3:0]  done;
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [3:0] d, input logic [31:0] rd, input logic er, input logic to);
        exp_t e;
        e.done  = d;
        e.rdata = rd;
        e.err   = er;
        e.to    = to;
        sb.push_back(e);
    endtask

    // Advance to the next falling edge and retire any completion against the scoreboard.
    task automatic tick();
        exp_t e;
        @(negedge pclk);
        if (preset_n) begin
            if (done != 4'b0000) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_done", 32'(done), 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("done_mask", 32'(done), 32'(e.done));
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
                end
            end else begin
                chk("rsp_idle", rsp_rdata | {30'd0, rsp_err, rsp_timeout}, 32'h0);
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   cyc;
        int   psel_n;
        int   pen_n;
        int   bad;
        int   dtick;
        logic got;
        req_write[v.idx]             = v.wr;
        req_addr[v.idx*16 +: 16]     = v.addr;
        req_wdata[v.idx*32 +: 32]    = v.wdata;
        prdata                       = v.prdata;
        pslverr                      = v.slverr;
        pready                       = 1'b0;
        req[v.idx]                   = 1'b1;
        push_exp(4'b0001 << v.idx, v.e_rdata, v.e_err, v.e_to);
        cyc = 0; psel_n = 0; pen_n = 0; bad = 0; dtick = 0; got = 1'b0;
        while (!got && cyc < 40) begin
            tick();
            cyc++;
            if (psel) begin
                psel_n++;
                if (paddr !== v.addr || pwrite !== v.wr || (v.wr && pwdata !== v.wdata)) bad++;
            end
            if (psel && !penable) begin
                // Disturb the granted slice; the transfer must not notice.
                req_addr[v.idx*16 +: 16]  = ~v.addr;
                req_wdata[v.idx*32 +: 32] = ~v.wdata;
                req_write[v.idx]          = ~v.wr;
            end
            if (penable) pen_n++;
            pready = penable && (pen_n == v.waits + 1);
            if (done != 4'b0000) begin
                got        = 1'b1;
                dtick      = cyc;
                req[v.idx] = 1'b0;
                pready     = 1'b0;
            end
        end
        chk("done_seen", 32'(got), 32'h1);
        chk("done_latency", 32'(dtick), 32'(2 + v.e_acc));
        chk("psel_cycles", 32'(psel_n), 32'(v.e_acc + 1));
        chk("penable_cycles", 32'(pen_n), 32'(v.e_acc));
        chk("apb_stable", 32'(bad), 32'h0);
        tick();
    endtask

    vec_t vecs[8];

    initial begin
        int         cyc;
        int         n_done;
        logic [3:0] rearm;
        logic       got;

        vecs[0] = '{0, 1'b1, 16'h0010, 32'hDEADBEEF, 32'h0,        1'b0, 0,   32'h0,        1'b0, 1'b0, 1};
        vecs[1] = '{2, 1'b0, 16'h0020, 32'h0,        32'h12345678, 1'b0, 3,   32'h12345678, 1'b0, 1'b0, 4};
        vecs[2] = '{1, 1'b0, 16'h0030, 32'h0,        32'hA5A50001, 1'b1, 0,   32'hA5A50001, 1'b1, 1'b0, 1};
        vecs[3] = '{3, 1'b1, 16'h0040, 32'h0BADF00D, 32'h77777777, 1'b1, 1,   32'h0,        1'b1, 1'b0, 2};
        vecs[4] = '{1, 1'b0, 16'h0050, 32'h0,        32'hFFFFFFFF, 1'b1, 255, 32'h0,        1'b1, 1'b1, 16};
        vecs[5] = '{2, 1'b0, 16'h0060, 32'h0,        32'hCAFE0001, 1'b0, 15,  32'hCAFE0001, 1'b0, 1'b0, 16};
        vecs[6] = '{0, 1'b1, 16'h0070, 32'h00000001, 32'h0,        1'b0, 255, 32'h0,        1'b1, 1'b1, 16};
        vecs[7] = '{2, 1'b0, 16'hFFFF, 32'h0,        32'h80000000, 1'b0, 2,   32'h80000000, 1'b0, 1'b0, 3};

        preset_n  = 1'b0;
        req       = '0;
        req_addr  = '0;
        req_write = '0;
        req_wdata = '0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        tick();
        tick();
        chk("rst_psel", 32'(psel), 32'h0);
        chk("rst_penable", 32'(penable), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_paddr", 32'(paddr), 32'h0);
        chk("rst_pwdata", pwdata, 32'h0);
        chk("rst_rsp", rsp_rdata | {30'd0, rsp_err, rsp_timeout}, 32'h0);
        preset_n = 1'b1;
        tick();

        // Round robin with every requester re-arming right after its done.
        req_write = 4'hF;
        for (int i = 0; i < 4; i++) begin
            req_addr[i*16 +: 16]  = 16'h0100 + 16'(i);
            req_wdata[i*32 +: 32] = 32'h1000 + 32'(i);
        end
        for (int i = 0; i < 5; i++) push_exp(4'b0001 << (i % 4), 32'h0, 1'b0, 1'b0);
        req = 4'hF; rearm = '0; n_done = 0; cyc = 0;
        while (n_done < 5 && cyc < 80) begin
            tick();
            cyc++;
            req   = req | rearm;
            rearm = '0;
            pready = penable;
            if (done != 4'b0000) begin
                n_done++;
                req = req & ~done;
                if (n_done < 5) rearm = done;
                else            req   = '0;
            end
        end
        chk("rr_grants", 32'(n_done), 32'h5);
        pready = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset in the middle of an ACCESS phase, then re-arbitrate from index 0.
        req_write[3]       = 1'b0;
        req_addr[48 +: 16] = 16'h0BBB;
        pready             = 1'b0;
        req                = 4'b1000;
        cyc = 0;
        while (!penable && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("rst_reached_access", 32'(penable), 32'h1);
        tick();
        #2 preset_n = 1'b0;
        #1;
        chk("arst_psel", 32'(psel), 32'h0);
        chk("arst_penable", 32'(penable), 32'h0);
        chk("arst_done", 32'(done), 32'h0);
        req = '0;
        tick();
        tick();
        preset_n = 1'b1;
        chk("arst_paddr", 32'(paddr), 32'h0);
        req_write             = 4'b1010;
        req_addr[16 +: 16]    = 16'h0111;
        req_addr[48 +: 16]    = 16'h0333;
        push_exp(4'b0010, 32'h0, 1'b0, 1'b0);
        req = 4'b1010; got = 1'b0; cyc = 0;
        while (!got && cyc < 20) begin
            tick();
            cyc++;
            if (psel) chk("regrant_paddr", 32'(paddr), 32'h0111);
            pready = penable;
            if (done != 4'b0000) begin
                got = 1'b1;
                req = '0;
            end
        end
        chk("regrant_seen", 32'(got), 32'h1);
        pready = 1'b0;
        tick();
        tick();
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
